// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: stage-0 pixel counters and decodes for pattern logic,
// stage-1 registered colour/sync pins aligned to one another.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_on,
    output logic       frame_start,
    input  logic [5:0] rgb_in,
    output logic [5:0] rgb_out,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hsync;
    logic       r_vsync;
    logic [5:0] r_rgb;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_display_on;
    logic       w_hsync_raw;
    logic       w_vsync_raw;

    always_comb begin
        w_h_last     = (r_h == 10'(H_TOTAL - 1));
        w_v_last     = (r_v == 10'(V_TOTAL - 1));
        w_display_on = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
        w_hsync_raw  = !((r_h >= 10'(H_ACTIVE + H_FP)) &&
                         (r_h <  10'(H_ACTIVE + H_FP + H_SYNC)));
        // v only moves on the h wrap, so this decode only changes at h==0
        w_vsync_raw  = !((r_v >= 10'(V_ACTIVE + V_FP)) &&
                         (r_v <  10'(V_ACTIVE + V_FP + V_SYNC)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_last ? '0 : r_h + 10'd1;
            if (w_h_last) begin
                r_v <= w_v_last ? '0 : r_v + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
            r_rgb   <= w_display_on ? rgb_in : '0;
        end
    end

    assign x           = r_h;
    assign y           = r_v;
    assign display_on  = w_display_on;
    assign frame_start = (r_h == '0) && (r_v == '0);
    assign rgb_out     = r_rgb;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance for line-level checks and a
// shrunken-timing instance for frame-level checks, both against a cycle-count model.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
    } timing_t;

    typedef struct {
        int         k;
        bit         hs;
        bit         vs;
        logic [5:0] rgb;
    } model_t;

    typedef struct {
        int k; int x; int y;
        bit don; bit fs; bit hs; bit vs;
    } vec_t;

    localparam timing_t TD = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t TS = '{20, 3, 5, 4, 6, 2, 2, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] rgb_d = '0, rgb_s = '0;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic       d_don, d_fs, d_hs, d_vs, s_don, s_fs, s_hs, s_vs;
    logic [5:0] d_rgb, s_rgb;

    int     total = 0;
    int     bad = 0;
    int     mode = 0;
    int     run_dh = 0, run_sh = 0, run_sv = 0;
    model_t md, ms;
    vec_t   tbl[11];

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .clk(clk), .rst(rst), .x(d_x), .y(d_y), .display_on(d_don),
        .frame_start(d_fs), .rgb_in(rgb_d), .rgb_out(d_rgb),
        .hsync(d_hs), .vsync(d_vs)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk(clk), .rst(rst), .x(s_x), .y(s_y), .display_on(s_don),
        .frame_start(s_fs), .rgb_in(rgb_s), .rgb_out(s_rgb),
        .hsync(s_hs), .vsync(s_vs)
    );

    function automatic int htot(timing_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int vtot(timing_t t);
        return t.va + t.vf + t.vs + t.vb;
    endfunction

    // Stage-0 view after k clocks since reset release, by plain arithmetic
    function automatic void stage0(input timing_t t, input int k, output int h, output int v,
                                   output bit don, output bit fs, output bit hr, output bit vr);
        h   = k % htot(t);
        v   = (k / htot(t)) % vtot(t);
        don = (h < t.ha) && (v < t.va);
        fs  = (h == 0) && (v == 0);
        hr  = !((h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs));
        vr  = !((v >= t.va + t.vf) && (v < t.va + t.vf + t.vs));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        md = '{0, 1'b1, 1'b1, 6'd0};
        ms = '{0, 1'b1, 1'b1, 6'd0};
        run_dh = 0; run_sh = 0; run_sv = 0;
    endtask

    task automatic check_all();
        int h, v;
        bit dn, fs, hr, vr;
        stage0(TD, md.k, h, v, dn, fs, hr, vr);
        chk($sformatf("d_x k=%0d", md.k), int'(d_x), h);
        chk($sformatf("d_y k=%0d", md.k), int'(d_y), v);
        chk($sformatf("d_don k=%0d", md.k), int'(d_don), int'(dn));
        chk($sformatf("d_fs k=%0d", md.k), int'(d_fs), int'(fs));
        chk($sformatf("d_hsync k=%0d", md.k), int'(d_hs), int'(md.hs));
        chk($sformatf("d_vsync k=%0d", md.k), int'(d_vs), int'(md.vs));
        chk($sformatf("d_rgb k=%0d", md.k), int'(d_rgb), int'(md.rgb));
        stage0(TS, ms.k, h, v, dn, fs, hr, vr);
        chk($sformatf("s_x k=%0d", ms.k), int'(s_x), h);
        chk($sformatf("s_y k=%0d", ms.k), int'(s_y), v);
        chk($sformatf("s_don k=%0d", ms.k), int'(s_don), int'(dn));
        chk($sformatf("s_fs k=%0d", ms.k), int'(s_fs), int'(fs));
        chk($sformatf("s_hsync k=%0d", ms.k), int'(s_hs), int'(ms.hs));
        chk($sformatf("s_vsync k=%0d", ms.k), int'(s_vs), int'(ms.vs));
        chk($sformatf("s_rgb k=%0d", ms.k), int'(s_rgb), int'(ms.rgb));
        // pulse widths measured directly on the pins
        if (!d_hs) run_dh++;
        else if (run_dh > 0) begin chk("d_hsync_low_len", run_dh, TD.hs); run_dh = 0; end
        if (!s_hs) run_sh++;
        else if (run_sh > 0) begin chk("s_hsync_low_len", run_sh, TS.hs); run_sh = 0; end
        if (!s_vs) run_sv++;
        else if (run_sv > 0) begin chk("s_vsync_low_len", run_sv, TS.vs * htot(TS)); run_sv = 0; end
    endtask

    task automatic drive_rgb();
        case (mode)
            0: begin rgb_d = 6'($urandom); rgb_s = 6'($urandom); end
            1: begin rgb_d = 6'h3F; rgb_s = 6'h3F; end
            default: begin
                rgb_d = 6'(md.k % htot(TD));
                rgb_s = 6'(ms.k % htot(TS));
            end
        endcase
    endtask

    task automatic tick();
        int h, v;
        bit dn, fs, hr, vr;
        model_t nd, ns;
        stage0(TD, md.k, h, v, dn, fs, hr, vr);
        nd = '{md.k + 1, hr, vr, dn ? rgb_d : 6'd0};
        stage0(TS, ms.k, h, v, dn, fs, hr, vr);
        ns = '{ms.k + 1, hr, vr, dn ? rgb_s : 6'd0};
        @(posedge clk);
        if (!rst) begin
            md = nd;
            ms = ns;
        end
        @(negedge clk);
        check_all();
        drive_rgb();
    endtask

    task automatic wait_small(input int h, input int v, input string nm);
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if ((ms.k % htot(TS) == h) && ((ms.k / htot(TS)) % vtot(TS) == v)) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk({"wait_", nm}, int'(ok), 1);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c3f, c0, first, fsc, rises;
        bit pv, ok;

        tbl[0]  = '{0,    0,   0, 1, 1, 1, 1};
        tbl[1]  = '{1,    1,   0, 1, 0, 1, 1};
        tbl[2]  = '{639,  639, 0, 1, 0, 1, 1};
        tbl[3]  = '{640,  640, 0, 0, 0, 1, 1};
        tbl[4]  = '{656,  656, 0, 0, 0, 1, 1};
        tbl[5]  = '{657,  657, 0, 0, 0, 0, 1};
        tbl[6]  = '{752,  752, 0, 0, 0, 0, 1};
        tbl[7]  = '{753,  753, 0, 0, 0, 1, 1};
        tbl[8]  = '{799,  799, 0, 0, 0, 1, 1};
        tbl[9]  = '{800,  0,   1, 1, 0, 1, 1};
        tbl[10] = '{1000, 200, 1, 1, 0, 1, 1};

        model_reset();
        mode = 0;
        @(negedge clk);
        check_all();
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            while (md.k < tbl[i].k) tick();
            chk($sformatf("vec%0d_x", i),  int'(d_x),   tbl[i].x);
            chk($sformatf("vec%0d_y", i),  int'(d_y),   tbl[i].y);
            chk($sformatf("vec%0d_don", i), int'(d_don), int'(tbl[i].don));
            chk($sformatf("vec%0d_fs", i), int'(d_fs),  int'(tbl[i].fs));
            chk($sformatf("vec%0d_hs", i), int'(d_hs),  int'(tbl[i].hs));
            chk($sformatf("vec%0d_vs", i), int'(d_vs),  int'(tbl[i].vs));
        end

        // constant white: one whole pin line = 640 lit clks + 160 blank clks
        mode = 1;
        drive_rgb();
        ok = 0;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (md.k % 800 == 1) begin ok = 1; break; end
        end
        chk("wait_line_start", int'(ok), 1);
        c3f = 0; c0 = 0;
        for (int i = 0; i < 800; i++) begin
            if (d_rgb == 6'h3F) c3f++;
            if (d_rgb == 6'h00) c0++;
            if (i < 799) tick();
        end
        chk("white_lit_clks", c3f, 640);
        chk("white_blank_clks", c0, 160);

        // x ramp: last visible value 3F, then blank
        mode = 2;
        drive_rgb();
        ok = 0;
        for (int i = 0; i < 900; i++) begin
            tick();
            if (md.k % 800 == 640) begin ok = 1; break; end
        end
        chk("wait_ramp_end", int'(ok), 1);
        chk("ramp_last_visible", int'(d_rgb), 6'h3F);
        tick();
        chk("ramp_after_visible", int'(d_rgb), 0);

        mode = 0;
        wait_small(31, 12, "wrap_frame");
        tick();
        chk("wrap_frame_x", int'(s_x), 0);
        chk("wrap_frame_y", int'(s_y), 0);
        chk("wrap_frame_fs", int'(s_fs), 1);
        wait_small(31, 5, "wrap_line");
        tick();
        chk("wrap_line_x", int'(s_x), 0);
        chk("wrap_line_y", int'(s_y), 6);

        // mid-frame reset: outputs must drop to idle without waiting for a clock
        wait_small(12, 4, "mid_frame");
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_now_hs", int'(s_hs), 1);
        chk("rst_now_vs", int'(s_vs), 1);
        chk("rst_now_rgb", int'(s_rgb), 0);
        chk("rst_now_x", int'(s_x), 0);
        chk("rst_now_y", int'(s_y), 0);
        chk("rst_now_dx", int'(d_x), 0);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        first = -1; fsc = 0; rises = 0; pv = s_vs;
        for (int i = 1; i <= 2 * 416; i++) begin
            tick();
            if (s_fs) begin
                fsc++;
                if (first < 0) first = ms.k;
            end
            if (s_vs && !pv) rises++;
            pv = s_vs;
        end
        chk("next_frame_start_at", first, 416);
        chk("frame_starts_2frames", fsc, 2);
        chk("vsync_rises_2frames", rises, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
